pipelined_anurupyena_mult: RTL and testbench

PIPELINED_ANURUPYENA_MULT -- requirements
Module: pipelined_anurupyena_mult

---
 rtl/pipelined_anurupyena_mult.sv | 143 ++++++++++++++
 tb/tb_pipelined_anurupyena_mult.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_anurupyena_mult.sv
// Three-stage signed multiplier using the Anurupyena base-deviation method.
// Base B = 2^(N-1): dx = X-B, dy = Y-B, X*Y = B*(X+dy) + dx*dy.
// Optional running accumulator compiled in with `define ANURUPYENA_ACC_EN.
module pipelined_anurupyena_mult #(
  parameter int unsigned N         = 8,
  parameter int unsigned ACC_GUARD = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [N-1:0]   X,
  input  logic signed [N-1:0]   Y,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [2*N-1:0] Result
`ifdef ANURUPYENA_ACC_EN
  ,
  input  logic                            acc_clr,
  output logic signed [2*N+ACC_GUARD-1:0] Acc,
  output logic                            acc_ovf
`endif
);

  localparam int unsigned DW = N + 2;      // deviation / X+dy width
  localparam int unsigned HW = 2 * N + 1;  // B*(X+dy) width
  localparam int unsigned LW = 2 * N + 2;  // dx*dy and full-sum width
  localparam int unsigned RW = 2 * N;      // product width
  localparam logic signed [DW-1:0] BASE = DW'(1) << (N - 1);

  // Reject operand widths the shift/deviation arithmetic is not sized for
  if ((N % 2) != 0 || N < 4 || N > 32 || ACC_GUARD > 64) begin : g_bad_param
    $error("pipelined_anurupyena_mult: illegal N or ACC_GUARD");
  end

  logic                 stall_c;
  logic signed [DW-1:0] xe_c, ye_c, dx_c, dy_c, xdy_c;
  logic signed [RW-1:0] sum_c;

  logic                 s1_valid, s2_valid;
  logic signed [DW-1:0] s1_dx, s1_dy, s1_xdy;
  logic signed [HW-1:0] s2_hi;
  logic signed [LW-1:0] s2_lo;

  // The whole pipe freezes while the output holds an unaccepted result
  assign stall_c  = out_valid & ~out_ready;
  assign in_ready = ~stall_c;

  // Deviations from the base, all kept at N+2 bits
  assign xe_c  = DW'(X);
  assign ye_c  = DW'(Y);
  assign dx_c  = xe_c - BASE;
  assign dy_c  = ye_c - BASE;
  assign xdy_c = xe_c + dy_c;

  // Final recombination; the exact product always fits 2N bits
  assign sum_c = RW'(LW'(s2_hi) + s2_lo);

  // Stage 1: register deviations and cross term
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_dx    <= '0;
      s1_dy    <= '0;
      s1_xdy   <= '0;
    end else if (!stall_c) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_dx  <= dx_c;
        s1_dy  <= dy_c;
        s1_xdy <= xdy_c;
      end
    end
  end

  // Stage 2: base-scaled term (pure shift) and deviation product
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_hi    <= '0;
      s2_lo    <= '0;
    end else if (!stall_c) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_hi <= $signed({s1_xdy, {(N - 1){1'b0}}});
        s2_lo <= LW'(s1_dx) * LW'(s1_dy);
      end
    end
  end

  // Stage 3: registered product and output valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      Result    <= '0;
    end else if (!stall_c) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        Result <= sum_c;
      end
    end
  end

`ifdef ANURUPYENA_ACC_EN
  localparam int unsigned AW = 2 * N + ACC_GUARD;

  logic                 s1_clr, s2_clr;
  logic signed [AW-1:0] acc_base_c, acc_add_c, acc_sum_c;
  logic                 acc_ovf_c;

  // Clear tag rides alongside its operand pair
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_clr <= 1'b0;
      s2_clr <= 1'b0;
    end else if (!stall_c) begin
      s1_clr <= in_valid & acc_clr;
      s2_clr <= s1_valid & s1_clr;
    end
  end

  // Signed add with overflow detect: same-sign operands, different-sign sum
  always_comb begin
    acc_base_c = s2_clr ? '0 : Acc;
    acc_add_c  = AW'(sum_c);
    acc_sum_c  = acc_base_c + acc_add_c;
    acc_ovf_c  = (acc_base_c[AW-1] == acc_add_c[AW-1]) &&
                 (acc_sum_c[AW-1] != acc_base_c[AW-1]);
  end

  // Accumulate only on valid pairs; overflow flag is sticky until a clear tag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Acc     <= '0;
      acc_ovf <= 1'b0;
    end else if (!stall_c && s2_valid) begin
      Acc     <= acc_sum_c;
      acc_ovf <= (s2_clr ? 1'b0 : acc_ovf) | acc_ovf_c;
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_anurupyena_mult.sv
module tb_pipelined_anurupyena_mult;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main DUT, N = 8
  logic               in_valid, in_ready, out_valid, out_ready;
  logic signed [7:0]  X, Y;
  logic signed [15:0] Result;

  // N = 4 exhaustive and N = 16 random instances
  logic               v4, r4, ov4, v16, r16, ov16, one;
  logic signed [3:0]  x4, y4;
  logic signed [7:0]  res4;
  logic signed [15:0] x16, y16;
  logic signed [31:0] res16;

`ifdef ANURUPYENA_ACC_EN
  logic               acc_clr, acc_ovf;
  logic signed [23:0] Acc;
  logic               a0_valid, a0_ready, a0_ovalid, a0_clr, a0_ovf;
  logic signed [7:0]  a0_x, a0_y;
  logic signed [15:0] a0_res, a0_acc;
  logic               zero;
  logic signed [11:0] acc4;
  logic               ovf4;
  logic signed [39:0] acc16;
  logic               ovf16;
`endif

  pipelined_anurupyena_mult #(.N(8), .ACC_GUARD(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .X(X), .Y(Y), .out_valid(out_valid), .out_ready(out_ready), .Result(Result)
`ifdef ANURUPYENA_ACC_EN
    , .acc_clr(acc_clr), .Acc(Acc), .acc_ovf(acc_ovf)
`endif
  );

  pipelined_anurupyena_mult #(.N(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4),
    .X(x4), .Y(y4), .out_valid(ov4), .out_ready(one), .Result(res4)
`ifdef ANURUPYENA_ACC_EN
    , .acc_clr(zero), .Acc(acc4), .acc_ovf(ovf4)
`endif
  );

  pipelined_anurupyena_mult #(.N(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16),
    .X(x16), .Y(y16), .out_valid(ov16), .out_ready(one), .Result(res16)
`ifdef ANURUPYENA_ACC_EN
    , .acc_clr(zero), .Acc(acc16), .acc_ovf(ovf16)
`endif
  );

`ifdef ANURUPYENA_ACC_EN
  pipelined_anurupyena_mult #(.N(8), .ACC_GUARD(0)) ua0 (
    .clk(clk), .rst(rst), .in_valid(a0_valid), .in_ready(a0_ready),
    .X(a0_x), .Y(a0_y), .out_valid(a0_ovalid), .out_ready(one), .Result(a0_res),
    .acc_clr(a0_clr), .Acc(a0_acc), .acc_ovf(a0_ovf)
  );
`endif

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic signed [7:0] x;
    logic signed [7:0] y;
    longint            exp;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];
  vec_t stl  [3];
  vec_t rstv [3];

  longint e4  [256];
  longint e16 [300];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{8'sd27,   8'sd5,    135};
    vecs[1] = '{-8'sd16,  8'sd15,   -240};
    vecs[2] = '{-8'sd1,   -8'sd1,   1};
    vecs[3] = '{-8'sd128, -8'sd128, 16384};
    vecs[4] = '{8'sd127,  -8'sd1,   -127};
    vecs[5] = '{-8'sd86,  8'sd85,   -7310};
    vecs[6] = '{8'sd0,    -8'sd128, 0};
    vecs[7] = '{8'sd127,  8'sd127,  16129};
    vecs[8] = '{-8'sd128, 8'sd127,  -16256};
    stl[0]  = '{8'sd10,   -8'sd3,   -30};
    stl[1]  = '{-8'sd7,   -8'sd9,   63};
    stl[2]  = '{8'sd100,  8'sd50,   5000};
    rstv[0] = '{8'sd3,    8'sd4,    12};
    rstv[1] = '{8'sd5,    8'sd6,    30};
    rstv[2] = '{-8'sd2,   8'sd7,    -14};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; X = '0; Y = '0; one = 1'b1;
    v4 = 1'b0; x4 = '0; y4 = '0; v16 = 1'b0; x16 = '0; y16 = '0;
`ifdef ANURUPYENA_ACC_EN
    acc_clr = 1'b0; zero = 1'b0;
    a0_valid = 1'b0; a0_x = '0; a0_y = '0; a0_clr = 1'b0;
`endif
    #2;
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_result", longint'(Result), 0);
    chk("reset_in_ready", longint'(in_ready), 1);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Single pair latency
    X = 8'sd27; Y = 8'sd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat_c1_valid", longint'(out_valid), 0);
    tick();
    chk("lat_c2_valid", longint'(out_valid), 0);
    tick();
    chk("lat_c3_valid", longint'(out_valid), 1);
    chk("lat_c3_result", longint'(Result), 135);
    tick();
    chk("lat_no_dup", longint'(out_valid), 0);

    // Back-to-back table, one result per cycle
    for (int i = 0; i < NV + 2; i++) begin
      if (i < NV) begin
        X = vecs[i].x; Y = vecs[i].y; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 2) begin
        chk($sformatf("b2b_valid_%0d", i - 2), longint'(out_valid), 1);
        chk($sformatf("b2b_result_%0d", i - 2), longint'(Result), vecs[i - 2].exp);
      end
    end
    tick();
    chk("b2b_drained", longint'(out_valid), 0);

    // Stall with three pairs in flight
    for (int k = 0; k < 3; k++) begin
      X = stl[k].x; Y = stl[k].y; in_valid = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    X = 8'sd55; Y = 8'sd55;
    #1;
    chk("stall_in_ready", longint'(in_ready), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("stall_hold_valid_%0d", k), longint'(out_valid), 1);
      chk($sformatf("stall_hold_result_%0d", k), longint'(Result), stl[0].exp);
      chk($sformatf("stall_hold_ready_%0d", k), longint'(in_ready), 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("stall_release_ready", longint'(in_ready), 1);
    tick();
    chk("stall_out1_valid", longint'(out_valid), 1);
    chk("stall_out1_result", longint'(Result), stl[1].exp);
    tick();
    chk("stall_out2_valid", longint'(out_valid), 1);
    chk("stall_out2_result", longint'(Result), stl[2].exp);
    tick();
    chk("stall_no_extra", longint'(out_valid), 0);

    // Asynchronous reset with pairs in flight
    for (int k = 0; k < 3; k++) begin
      X = rstv[k].x; Y = rstv[k].y; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("prerst_result", longint'(Result), rstv[0].exp);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", longint'(out_valid), 0);
    chk("rst_async_result", longint'(Result), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("rst_flushed_%0d", k), longint'(out_valid), 0);
    end
    X = 8'sd9; Y = 8'sd9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("post_rst_valid", longint'(out_valid), 1);
    chk("post_rst_result", longint'(Result), 81);

    // N = 4 exhaustive sweep
    for (int i = 0; i < 258; i++) begin
      if (i < 256) begin
        x4 = 4'(i >> 4); y4 = 4'(i);
        e4[i] = longint'(x4) * longint'(y4);
        v4 = 1'b1;
      end else begin
        v4 = 1'b0;
      end
      tick();
      if (i >= 2) begin
        if (ov4 !== 1'b1) chk($sformatf("n4_valid_%0d", i - 2), longint'(ov4), 1);
        else chk($sformatf("n4_result_%0d", i - 2), longint'(res4), e4[i - 2]);
      end
    end
    chk("n4_in_ready", longint'(r4), 1);

    // N = 16 random sweep, corners first
    for (int i = 0; i < 302; i++) begin
      if (i < 300) begin
        if (i == 0) begin x16 = 16'sh8000; y16 = 16'sh8000; end
        else if (i == 1) begin x16 = 16'sh7fff; y16 = 16'sh8000; end
        else begin x16 = 16'($urandom); y16 = 16'($urandom); end
        e16[i] = longint'(x16) * longint'(y16);
        v16 = 1'b1;
      end else begin
        v16 = 1'b0;
      end
      tick();
      if (i >= 2) begin
        if (ov16 !== 1'b1) chk($sformatf("n16_valid_%0d", i - 2), longint'(ov16), 1);
        else chk($sformatf("n16_result_%0d", i - 2), longint'(res16), e16[i - 2]);
      end
    end
    chk("n16_in_ready", longint'(r16), 1);

`ifdef ANURUPYENA_ACC_EN
    // Four (127,127) pairs, the first restarting the sum
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        X = 8'sd127; Y = 8'sd127; in_valid = 1'b1; acc_clr = (i == 0);
      end else begin
        in_valid = 1'b0; acc_clr = 1'b0;
      end
      tick();
      if (i >= 2) chk($sformatf("acc_run_%0d", i - 2), longint'(Acc), 16129 * (i - 1));
    end
    chk("acc_final_ovf", longint'(acc_ovf), 0);

    // Zero guard bits: 16384 + 16384 overflows 16 bits, then a clear recovers
    for (int i = 0; i < 5; i++) begin
      if (i < 2) begin
        a0_x = -8'sd128; a0_y = -8'sd128; a0_clr = (i == 0); a0_valid = 1'b1;
      end else if (i == 2) begin
        a0_x = 8'sd1; a0_y = 8'sd1; a0_clr = 1'b1; a0_valid = 1'b1;
      end else begin
        a0_valid = 1'b0; a0_clr = 1'b0;
      end
      tick();
      if (i == 2) chk("g0_first_ovf", longint'(a0_ovf), 0);
      if (i == 3) chk("g0_second_ovf", longint'(a0_ovf), 1);
      if (i == 4) begin
        chk("g0_clear_ovf", longint'(a0_ovf), 0);
        chk("g0_clear_acc", longint'(a0_acc), 1);
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
